ap_ctrl_txn_profiler: RTL and testbench

Cycle-accurate transaction profiler placed directly downstream of the ap_ctrl handshake taps of one HLS-generated module. It timestamps every accepted start (ap_start & ap_ready), pairs it with the matching completion (ap_done & ap_continue) in FIFO order, and emits one latency/interval record per transaction over a valid/ready stream consumed by the CSV status dumper. Overlapping transactions from pipelined or dataflow modules are supported up to DEPTH outstanding.

---
 rtl/ap_ctrl_txn_profiler_pkg.sv | 23 ++
 rtl/ap_ctrl_txn_profiler_if.sv | 27 ++
 rtl/ap_ctrl_txn_profiler_ts_fifo.sv | 38 +++
 rtl/ap_ctrl_txn_profiler.sv | 178 +++++++++++++++++
 tb/tb_ap_ctrl_txn_profiler.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/ap_ctrl_txn_profiler_pkg.sv
// Shared types for the ap_ctrl transaction profiler: record layout, FSM states, widths.
package ap_ctrl_prof_pkg;

   localparam int PROF_CNT_W = 32;
   localparam int PROF_ID_W  = 16;
   localparam int DROP_W     = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } prof_state_e;

   typedef struct packed {
      logic [PROF_ID_W-1:0]  id;
      logic [PROF_CNT_W-1:0] start_ts;
      logic [PROF_CNT_W-1:0] latency;
      logic [PROF_CNT_W-1:0] interval;
      logic [PROF_CNT_W-1:0] stall;
   } prof_rec_t;

endpackage

// File: rtl/ap_ctrl_txn_profiler_if.sv
// ap_ctrl tap inputs plus the record output stream of the transaction profiler.
interface ap_ctrl_txn_profiler_if #(
   parameter int CNT_W = 32,
   parameter int ID_W  = 16
) ();
   logic             ap_start;
   logic             ap_ready;
   logic             ap_done;
   logic             ap_continue;
   logic             rec_valid;
   logic             rec_ready;
   logic [ID_W-1:0]  rec_id;
   logic [CNT_W-1:0] rec_start_ts;
   logic [CNT_W-1:0] rec_latency;
   logic [CNT_W-1:0] rec_interval;
   logic [CNT_W-1:0] rec_stall;

   modport master (
      output ap_start, ap_ready, ap_done, ap_continue, rec_ready,
      input  rec_valid, rec_id, rec_start_ts, rec_latency, rec_interval, rec_stall
   );

   modport slave (
      input  ap_start, ap_ready, ap_done, ap_continue, rec_ready,
      output rec_valid, rec_id, rec_start_ts, rec_latency, rec_interval, rec_stall
   );
endinterface

// File: rtl/ap_ctrl_txn_profiler_ts_fifo.sv
// Timestamp FIFO holding {ts, interval, stall} per outstanding transaction; head is read combinationally.
module prof_ts_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 96
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   assign rdata = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/ap_ctrl_txn_profiler.sv
// Pairs ap_ctrl starts with completions in FIFO order and emits one latency/interval record each.
// Optional stall counting is enabled with `define AP_CTRL_PROF_STALL_EN.
//
// state | meaning
// IDLE  | waiting for the first accepted start
// RUN   | profiling starts and completions
// FLUSH | finish seen; completions drained, new starts ignored
// DONE  | drained and output empty; terminal until reset
module ap_ctrl_txn_profiler
   import ap_ctrl_prof_pkg::*;
#(
   parameter int CNT_W = PROF_CNT_W,
   parameter int ID_W  = PROF_ID_W,
   parameter int DEPTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  finish,
   ap_ctrl_txn_profiler_if.slave bus,
   output logic [DROP_W-1:0]     drop_cnt,
   output logic                  err_overflow,
   output logic                  err_underflow,
   output logic                  flushed
);
   prof_state_e state_q, state_d;

   logic [CNT_W-1:0]   cyc;
   logic [CNT_W-1:0]   last_start;
   logic               has_start;
   logic [ID_W-1:0]    done_id;
   logic [CNT_W-1:0]   stall_now;
   logic [CNT_W-1:0]   interval_now;
   logic               start_ev, done_ev;
   logic               start_ok, done_ok;
   logic               start_acc, done_acc;
   logic               push, pop, bypass, overflow, underflow;
   logic               fifo_full, fifo_empty;
   logic [3*CNT_W-1:0] fifo_wdata, fifo_rdata;
   logic [CNT_W-1:0]   head_ts;
   logic               new_valid;
   prof_rec_t          new_rec;
   prof_rec_t          rec_q;
   logic               rec_valid_q;

   assign start_ev = bus.ap_start & bus.ap_ready;
   assign done_ev  = bus.ap_done & bus.ap_continue;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      start_ok = 1'b0;
      done_ok  = 1'b0;
      case (state_q)
         IDLE: begin
            start_ok = 1'b1;
            done_ok  = 1'b1;
            if (start_ev) state_d = RUN;
         end
         RUN: begin
            start_ok = 1'b1;
            done_ok  = 1'b1;
            if (finish) state_d = FLUSH;
         end
         FLUSH: begin
            done_ok = 1'b1;
            if (fifo_empty && !rec_valid_q) state_d = DONE;
         end
         DONE: ;
         default: state_d = IDLE;
      endcase
   end

   // A start arriving while full is still taken if a completion frees a slot the same cycle.
   always_comb begin
      start_acc    = start_ok & start_ev;
      done_acc     = done_ok & done_ev;
      interval_now = has_start ? (cyc - last_start) : '0;
      pop          = done_acc & ~fifo_empty;
      overflow     = start_acc & fifo_full & ~pop;
      bypass       = done_acc & fifo_empty & start_acc;
      underflow    = done_acc & fifo_empty & ~start_acc;
      push         = start_acc & ~overflow & ~bypass;
      new_valid    = pop | bypass;
   end

   assign fifo_wdata = {cyc, interval_now, stall_now};
   assign head_ts    = fifo_rdata[3*CNT_W-1:2*CNT_W];

   always_comb begin
      new_rec    = '0;
      new_rec.id = done_id;
      if (pop) begin
         new_rec.start_ts = head_ts;
         new_rec.latency  = cyc - head_ts;
         new_rec.interval = fifo_rdata[2*CNT_W-1:CNT_W];
         new_rec.stall    = fifo_rdata[CNT_W-1:0];
      end else begin
         new_rec.start_ts = cyc;
         new_rec.latency  = '0;
         new_rec.interval = interval_now;
         new_rec.stall    = stall_now;
      end
   end

   prof_ts_fifo #(
      .DEPTH (DEPTH),
      .W     (3*CNT_W)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (fifo_wdata),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

`ifdef AP_CTRL_PROF_STALL_EN
   logic [CNT_W-1:0] stall_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)                                stall_cnt <= '0;
      else if (start_ev)                        stall_cnt <= '0;
      else if (bus.ap_start && !bus.ap_ready)   stall_cnt <= stall_cnt + 1'b1;
   end

   assign stall_now = stall_cnt;
`else
   assign stall_now = '0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cyc           <= '0;
         last_start    <= '0;
         has_start     <= 1'b0;
         done_id       <= '0;
         rec_q         <= '0;
         rec_valid_q   <= 1'b0;
         drop_cnt      <= '0;
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
         flushed       <= 1'b0;
      end else begin
         cyc <= cyc + 1'b1;
         if (start_acc && !overflow) begin
            last_start <= cyc;
            has_start  <= 1'b1;
         end
         if (overflow)  err_overflow  <= 1'b1;
         if (underflow) err_underflow <= 1'b1;
         if (new_valid) begin
            done_id <= done_id + 1'b1;
            if (!rec_valid_q || bus.rec_ready) begin
               rec_q       <= new_rec;
               rec_valid_q <= 1'b1;
            end else if (drop_cnt != '1) begin
               drop_cnt <= drop_cnt + 1'b1;
            end
         end else if (bus.rec_ready) begin
            rec_valid_q <= 1'b0;
         end
         flushed <= (state_d == DONE);
      end
   end

   assign bus.rec_valid    = rec_valid_q;
   assign bus.rec_id       = rec_q.id;
   assign bus.rec_start_ts = rec_q.start_ts;
   assign bus.rec_latency  = rec_q.latency;
   assign bus.rec_interval = rec_q.interval;
   assign bus.rec_stall    = rec_q.stall;
endmodule

// File: tb/tb_ap_ctrl_txn_profiler.sv
// Directed self-checking bench for ap_ctrl_txn_profiler.
module tb_ap_ctrl_txn_profiler;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        finish = 1'b0;
   logic [15:0] drop_cnt;
   logic        err_overflow, err_underflow, flushed;
   int          checks = 0;
   int          failures = 0;
   int          tb_cyc = 0;

   ap_ctrl_txn_profiler_if #(.CNT_W(32), .ID_W(16)) bus ();

   ap_ctrl_txn_profiler #(.CNT_W(32), .ID_W(16), .DEPTH(8)) dut (
      .clock         (clock),
      .reset         (reset),
      .finish        (finish),
      .bus           (bus),
      .drop_cnt      (drop_cnt),
      .err_overflow  (err_overflow),
      .err_underflow (err_underflow),
      .flushed       (flushed)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
      tb_cyc++;
   endtask

   task automatic run_to(input int n);
      while (tb_cyc < n) tick();
   endtask

   task automatic pulse(input logic st, input logic dn);
      bus.ap_start = st;
      bus.ap_ready = st;
      bus.ap_done  = dn;
      tick();
      bus.ap_start = 1'b0;
      bus.ap_ready = 1'b0;
      bus.ap_done  = 1'b0;
   endtask

   task automatic do_reset(input logic ready);
      reset           = 1'b1;
      finish          = 1'b0;
      bus.ap_start    = 1'b0;
      bus.ap_ready    = 1'b0;
      bus.ap_done     = 1'b0;
      bus.ap_continue = 1'b1;
      bus.rec_ready   = ready;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset  = 1'b0;
      tb_cyc = 0;
   endtask

   task automatic test_reset();
      do_reset(1'b1);
      checks++; if (bus.rec_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.rec_valid); end
      checks++; if (bus.rec_id !== 16'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", bus.rec_id); end
      checks++; if (bus.rec_start_ts !== 32'd0) begin failures++; $display("FAIL reset_ts got=%0d exp=0", bus.rec_start_ts); end
      checks++; if (bus.rec_latency !== 32'd0) begin failures++; $display("FAIL reset_lat got=%0d exp=0", bus.rec_latency); end
      checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
      checks++; if ({err_overflow, err_underflow, flushed} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {err_overflow, err_underflow, flushed}); end
   endtask

   task automatic test_single();
      do_reset(1'b1);
      run_to(10);
      pulse(1'b1, 1'b0);
      run_to(25);
      checks++; if (bus.rec_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%0b exp=0", bus.rec_valid); end
      pulse(1'b0, 1'b1);
      checks++; if (bus.rec_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", bus.rec_valid); end
      checks++; if (bus.rec_id !== 16'd0) begin failures++; $display("FAIL single_id got=%0d exp=0", bus.rec_id); end
      checks++; if (bus.rec_start_ts !== 32'd10) begin failures++; $display("FAIL single_ts got=%0d exp=10", bus.rec_start_ts); end
      checks++; if (bus.rec_latency !== 32'd15) begin failures++; $display("FAIL single_lat got=%0d exp=15", bus.rec_latency); end
      checks++; if (bus.rec_interval !== 32'd0) begin failures++; $display("FAIL single_int got=%0d exp=0", bus.rec_interval); end
      checks++; if (bus.rec_stall !== 32'd0) begin failures++; $display("FAIL single_stall got=%0d exp=0", bus.rec_stall); end
   endtask

   task automatic test_overlap();
      int st[3] = '{5, 7, 9};
      int dn[3] = '{20, 22, 24};
      int iv[3] = '{0, 2, 2};
      do_reset(1'b1);
      for (int i = 0; i < 3; i++) begin
         run_to(st[i]);
         pulse(1'b1, 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
         run_to(dn[i]);
         pulse(1'b0, 1'b1);
         checks++; if (bus.rec_valid !== 1'b1 || bus.rec_id !== 16'(i)) begin failures++; $display("FAIL overlap_id[%0d] got=%0b/%0d exp=1/%0d", i, bus.rec_valid, bus.rec_id, i); end
         checks++; if (bus.rec_start_ts !== 32'(st[i])) begin failures++; $display("FAIL overlap_ts[%0d] got=%0d exp=%0d", i, bus.rec_start_ts, st[i]); end
         checks++; if (bus.rec_latency !== 32'd15) begin failures++; $display("FAIL overlap_lat[%0d] got=%0d exp=15", i, bus.rec_latency); end
         checks++; if (bus.rec_interval !== 32'(iv[i])) begin failures++; $display("FAIL overlap_int[%0d] got=%0d exp=%0d", i, bus.rec_interval, iv[i]); end
      end
   endtask

   task automatic test_same_cycle();
      do_reset(1'b1);
      run_to(10); pulse(1'b1, 1'b0);
      run_to(12); pulse(1'b0, 1'b1);
      run_to(30); pulse(1'b1, 1'b1);
      checks++; if (bus.rec_valid !== 1'b1 || bus.rec_id !== 16'd1) begin failures++; $display("FAIL bypass_id got=%0b/%0d exp=1/1", bus.rec_valid, bus.rec_id); end
      checks++; if (bus.rec_start_ts !== 32'd30 || bus.rec_latency !== 32'd0) begin failures++; $display("FAIL bypass_ts_lat got=%0d/%0d exp=30/0", bus.rec_start_ts, bus.rec_latency); end
      checks++; if (bus.rec_interval !== 32'd20) begin failures++; $display("FAIL bypass_int got=%0d exp=20", bus.rec_interval); end
      checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL bypass_underflow got=%0b exp=0", err_underflow); end
      run_to(40); pulse(1'b1, 1'b0);
      run_to(42); pulse(1'b1, 1'b0);
      run_to(45); pulse(1'b1, 1'b1);
      checks++; if (bus.rec_start_ts !== 32'd40 || bus.rec_latency !== 32'd5 || bus.rec_interval !== 32'd10) begin failures++; $display("FAIL swap_rec got=%0d/%0d/%0d exp=40/5/10", bus.rec_start_ts, bus.rec_latency, bus.rec_interval); end
      run_to(50); pulse(1'b0, 1'b1);
      checks++; if (bus.rec_start_ts !== 32'd42 || bus.rec_latency !== 32'd8 || bus.rec_id !== 16'd3) begin failures++; $display("FAIL occ_rec1 got=%0d/%0d/%0d exp=42/8/3", bus.rec_start_ts, bus.rec_latency, bus.rec_id); end
      pulse(1'b0, 1'b1);
      checks++; if (bus.rec_start_ts !== 32'd45 || bus.rec_latency !== 32'd6 || bus.rec_interval !== 32'd3) begin failures++; $display("FAIL occ_rec2 got=%0d/%0d/%0d exp=45/6/3", bus.rec_start_ts, bus.rec_latency, bus.rec_interval); end
      run_to(55); pulse(1'b0, 1'b1);
      checks++; if (bus.rec_valid !== 1'b0 || err_underflow !== 1'b1) begin failures++; $display("FAIL occ_drained got=%0b/%0b exp=0/1", bus.rec_valid, err_underflow); end
   endtask

   task automatic test_back_to_back();
      do_reset(1'b0);
      run_to(3); pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      run_to(10); pulse(1'b0, 1'b1);
      checks++; if (bus.rec_valid !== 1'b1 || drop_cnt !== 16'd0) begin failures++; $display("FAIL bp_first got=%0b/%0d exp=1/0", bus.rec_valid, drop_cnt); end
      pulse(1'b0, 1'b1);
      checks++; if (bus.rec_id !== 16'd0 || bus.rec_start_ts !== 32'd3 || bus.rec_latency !== 32'd7) begin failures++; $display("FAIL bp_held got=%0d/%0d/%0d exp=0/3/7", bus.rec_id, bus.rec_start_ts, bus.rec_latency); end
      checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL bp_drop got=%0d exp=1", drop_cnt); end
      bus.rec_ready = 1'b1;
      tick();
      checks++; if (bus.rec_valid !== 1'b0) begin failures++; $display("FAIL bp_consumed got=%0b exp=0", bus.rec_valid); end
   endtask

   task automatic test_overflow();
      do_reset(1'b1);
      run_to(5); pulse(1'b0, 1'b1);
      checks++; if (err_underflow !== 1'b1 || bus.rec_valid !== 1'b0) begin failures++; $display("FAIL idle_underflow got=%0b/%0b exp=1/0", err_underflow, bus.rec_valid); end
      do_reset(1'b1);
      for (int i = 1; i <= 9; i++) begin
         run_to(i);
         pulse(1'b1, 1'b0);
         if (i == 8) begin
            checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%0b exp=0", err_overflow); end
         end
      end
      checks++; if (err_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", err_overflow); end
      for (int i = 0; i < 8; i++) begin
         run_to(20 + i);
         pulse(1'b0, 1'b1);
         checks++; if (bus.rec_id !== 16'(i) || bus.rec_start_ts !== 32'(i + 1) || bus.rec_latency !== 32'd19) begin failures++; $display("FAIL ovf_rec[%0d] got=%0d/%0d/%0d exp=%0d/%0d/19", i, bus.rec_id, bus.rec_start_ts, bus.rec_latency, i, i + 1); end
      end
      run_to(30); pulse(1'b0, 1'b1);
      checks++; if (bus.rec_valid !== 1'b0 || err_underflow !== 1'b1) begin failures++; $display("FAIL ovf_ninth got=%0b/%0b exp=0/1", bus.rec_valid, err_underflow); end
   endtask

   task automatic test_flush();
      do_reset(1'b1);
      run_to(2); pulse(1'b1, 1'b0);
      run_to(4); pulse(1'b1, 1'b0);
      run_to(6); finish = 1'b1; tick();
      run_to(8); pulse(1'b1, 1'b0);
      run_to(12); pulse(1'b0, 1'b1);
      checks++; if (bus.rec_start_ts !== 32'd2 || bus.rec_latency !== 32'd10) begin failures++; $display("FAIL flush_rec0 got=%0d/%0d exp=2/10", bus.rec_start_ts, bus.rec_latency); end
      run_to(14);
      checks++; if (flushed !== 1'b0) begin failures++; $display("FAIL flush_early got=%0b exp=0", flushed); end
      pulse(1'b0, 1'b1);
      checks++; if (bus.rec_id !== 16'd1 || bus.rec_start_ts !== 32'd4 || bus.rec_interval !== 32'd2) begin failures++; $display("FAIL flush_rec1 got=%0d/%0d/%0d exp=1/4/2", bus.rec_id, bus.rec_start_ts, bus.rec_interval); end
      tick();
      checks++; if (bus.rec_valid !== 1'b0 || flushed !== 1'b0) begin failures++; $display("FAIL flush_pre got=%0b/%0b exp=0/0", bus.rec_valid, flushed); end
      tick();
      checks++; if (flushed !== 1'b1) begin failures++; $display("FAIL flush_done got=%0b exp=1", flushed); end

      do_reset(1'b0);
      run_to(2); pulse(1'b1, 1'b0);
      run_to(6); finish = 1'b1; tick();
      run_to(10); pulse(1'b0, 1'b1);
      checks++; if (bus.rec_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_valid got=%0b exp=1", bus.rec_valid); end
      #1 reset = 1'b1;
      #1;
      checks++; if (bus.rec_valid !== 1'b0 || bus.rec_start_ts !== 32'd0 || bus.rec_latency !== 32'd0) begin failures++; $display("FAIL rst_async_rec got=%0b/%0d/%0d exp=0/0/0", bus.rec_valid, bus.rec_start_ts, bus.rec_latency); end
      checks++; if ({err_overflow, err_underflow, flushed} !== 3'b000 || drop_cnt !== 16'd0) begin failures++; $display("FAIL rst_async_flags got=%b/%0d exp=000/0", {err_overflow, err_underflow, flushed}, drop_cnt); end
      do_reset(1'b1);
      run_to(3); pulse(1'b0, 1'b1);
      checks++; if (bus.rec_valid !== 1'b0 || err_underflow !== 1'b1) begin failures++; $display("FAIL rst_fifo_cleared got=%0b/%0b exp=0/1", bus.rec_valid, err_underflow); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_overlap();
      test_same_cycle();
      test_back_to_back();
      test_overflow();
      test_flush();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
